key_input_ctrl: RTL

- Parametrised user-key input peripheral for the P8 board-level SoC. Sits on the CPU's bridge as a memory-mapped device.
- Per key channel:
  - synchronises raw active-low key pins;
  - debounces them;
  - detects press edges;
  - latches sticky pending bits.
- Raises a level interrupt to the CP0 hardware-interrupt line.
- Replaces the fixed 8-key raw read with a generalised, debounced, interrupt-capable block.

---
 rtl/key_input_ctrl.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/key_input_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : key_input_ctrl
// Purpose  : Memory-mapped user-key input peripheral. For each key channel it
//            synchronises the raw active-low pin, debounces it, detects the
//            press edge and latches a sticky pending bit. A registered level
//            interrupt is raised when an enabled channel has a pending event.
//
// Ports    : clk        system clock
//            reset      asynchronous active-high reset
//            key_n      raw key pins, active-low, asynchronous to clk
//            addr       word address within the block (byte addr[3:2], or
//                       [4:2] when release tracking is built in)
//            we         register write strobe
//            wdata      write data
//            rdata      read data, combinational from addr
//            key_state  debounced key level, 1 = pressed
//            irq        level interrupt request, registered
//
// Register map (unused upper bits read 0):
//            0 STATE            debounced key_state, read-only
//            1 PENDING          sticky press events, write-1-to-clear
//            2 MASK             per-key interrupt enable
//            3 CTRL             bit0 global interrupt enable
//            4 RELEASE_PENDING  sticky release events, write-1-to-clear
//                               (only with KEY_RELEASE_IRQ_EN)
//
// Build option : KEY_RELEASE_IRQ_EN - when defined, stable 1->0 transitions
//            set release_pending, addr widens to 3 bits and release events
//            also drive irq. When undefined no release logic exists.
//
// Parameters : N_KEYS 1..32, DEBOUNCE_CYCLES 2..65535,
//              CNT_W with 2**CNT_W > DEBOUNCE_CYCLES.
//
// Revision : 1.0 - initial release
// ============================================================================
module key_input_ctrl #(
    parameter int N_KEYS          = 8,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_KEYS-1:0] key_n,
`ifdef KEY_RELEASE_IRQ_EN
    input  logic [2:0]        addr,
`else
    input  logic [1:0]        addr,
`endif
    input  logic              we,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic [N_KEYS-1:0] key_state,
    output logic              irq
);

    localparam int ADDR_W = $bits(addr);

    localparam logic [ADDR_W-1:0] c_addr_state   = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] c_addr_pending = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] c_addr_mask    = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] c_addr_ctrl    = ADDR_W'(3);
`ifdef KEY_RELEASE_IRQ_EN
    localparam logic [ADDR_W-1:0] c_addr_relpend = ADDR_W'(4);
`endif

    // Terminal count: the counter value at which the next differing sample
    // is the DEBOUNCE_CYCLES-th one and the new level is accepted.
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    // ------------------------------------------------------------------------
    // Synchroniser. The chain carries the raw active-low pin level, so its
    // reset value of all-ones means "released".
    // ------------------------------------------------------------------------
    logic [N_KEYS-1:0] sync1_q;
    logic [N_KEYS-1:0] sync2_q;
    logic [N_KEYS-1:0] w_pressed;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= key_n;
            sync2_q <= sync1_q;
        end
    end

    assign w_pressed = ~sync2_q;

    // ------------------------------------------------------------------------
    // Debounce. The counter tracks how many consecutive synchronised samples
    // have differed from the accepted level; any agreeing sample restarts it.
    // ------------------------------------------------------------------------
    logic [N_KEYS-1:0] stable_q;
    logic [N_KEYS-1:0] stable_d;
    logic [CNT_W-1:0]  cnt_q [N_KEYS];
    logic [CNT_W-1:0]  cnt_d [N_KEYS];

    always_comb begin
        for (int i = 0; i < N_KEYS; i++) begin
            stable_d[i] = stable_q[i];
            cnt_d[i]    = cnt_q[i];
            if (w_pressed[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == c_cnt_last) begin
                stable_d[i] = w_pressed[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + c_cnt_one;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stable_q <= '0;
            for (int i = 0; i < N_KEYS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            stable_q <= stable_d;
            for (int i = 0; i < N_KEYS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign key_state = stable_q;

    // Edge events are taken from the accepted-level update itself so that
    // they coincide with the cycle key_state changes.
    logic [N_KEYS-1:0] w_press_evt;
    assign w_press_evt = stable_d & ~stable_q;

    // ------------------------------------------------------------------------
    // Register write decode
    // ------------------------------------------------------------------------
    logic w_wr_pending;
    logic w_wr_mask;
    logic w_wr_ctrl;

    assign w_wr_pending = we && (addr == c_addr_pending);
    assign w_wr_mask    = we && (addr == c_addr_mask);
    assign w_wr_ctrl    = we && (addr == c_addr_ctrl);

    // Write data truncated to the channel count; bits above N_KEYS are
    // ignored on write and read back as zero.
    logic [N_KEYS-1:0] w_wdata_keys;
    assign w_wdata_keys = wdata[N_KEYS-1:0];

    // The upper write-data bits have no destination in narrower builds.
    logic w_unused_wdata;
    assign w_unused_wdata = ^wdata;

    // ------------------------------------------------------------------------
    // Pending, mask and control registers. A new event is OR-ed in after the
    // W1C so that an event and its clear in the same cycle leave the bit set.
    // ------------------------------------------------------------------------
    logic [N_KEYS-1:0] pending_q;
    logic [N_KEYS-1:0] pending_d;
    logic [N_KEYS-1:0] mask_q;
    logic [N_KEYS-1:0] mask_d;
    logic              ctrl_en_q;
    logic              ctrl_en_d;
    logic              irq_q;
    logic              irq_d;
    logic [N_KEYS-1:0] w_irq_src;

    always_comb begin
        pending_d = pending_q;
        if (w_wr_pending) begin
            pending_d = pending_d & ~w_wdata_keys;
        end
        pending_d = pending_d | w_press_evt;
    end

    always_comb begin
        mask_d    = w_wr_mask ? w_wdata_keys : mask_q;
        ctrl_en_d = w_wr_ctrl ? wdata[0]     : ctrl_en_q;
    end

`ifdef KEY_RELEASE_IRQ_EN
    logic [N_KEYS-1:0] w_release_evt;
    logic              w_wr_relpend;
    logic [N_KEYS-1:0] relpend_q;
    logic [N_KEYS-1:0] relpend_d;

    assign w_release_evt = stable_q & ~stable_d;
    assign w_wr_relpend  = we && (addr == c_addr_relpend);

    always_comb begin
        relpend_d = relpend_q;
        if (w_wr_relpend) begin
            relpend_d = relpend_d & ~w_wdata_keys;
        end
        relpend_d = relpend_d | w_release_evt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            relpend_q <= '0;
        end else begin
            relpend_q <= relpend_d;
        end
    end

    assign w_irq_src = (pending_q | relpend_q) & mask_q;
`else
    assign w_irq_src = pending_q & mask_q;
`endif

    // irq is evaluated from the current register contents, so it follows any
    // pending/mask/ctrl update by exactly one cycle.
    assign irq_d = ctrl_en_q & (|w_irq_src);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_q <= '0;
            mask_q    <= '0;
            ctrl_en_q <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            mask_q    <= mask_d;
            ctrl_en_q <= ctrl_en_d;
            irq_q     <= irq_d;
        end
    end

    assign irq = irq_q;

    // ------------------------------------------------------------------------
    // Read mux. Every register is zero after reset, so rdata reads zero at
    // any address while reset is applied.
    // ------------------------------------------------------------------------
    always_comb begin
        rdata = '0;
        case (addr)
            c_addr_state:   rdata[N_KEYS-1:0] = stable_q;
            c_addr_pending: rdata[N_KEYS-1:0] = pending_q;
            c_addr_mask:    rdata[N_KEYS-1:0] = mask_q;
            c_addr_ctrl:    rdata[0]          = ctrl_en_q;
`ifdef KEY_RELEASE_IRQ_EN
            c_addr_relpend: rdata[N_KEYS-1:0] = relpend_q;
`endif
            default:        rdata = '0;
        endcase
    end

endmodule
`default_nettype wire
